mcdf_formatter: RTL

Packet formatter stage of the MCDF datapath, directly downstream of the channel arbiter. Requests a channel decision from the arbiter, latches the granted channel ID and package-length code, negotiates output ownership with the downstream consumer, then streams exactly one fixed-length packet with start/end framing. Flags framing mismatches between the slave's end marker and the decoded length.

---
 rtl/mcdf_formatter_pkg.sv | 36 +++
 rtl/mcdf_formatter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mcdf_formatter_pkg.sv
// mcdf_defs: shared definitions for the MCDF packet formatter.
//   - state_e    : formatter FSM state encoding
//   - LEN_*      : packet lengths in words
//   - ID_NONE    : arbiter ID meaning "no channel requesting"
//   - decode_len : package-length code -> packet length in words
package mcdf_defs;

  localparam int DW_DEF = 32;

  localparam logic [1:0] ID_NONE = 2'b11;

  localparam logic [5:0] LEN_4  = 6'd4;
  localparam logic [5:0] LEN_8  = 6'd8;
  localparam logic [5:0] LEN_16 = 6'd16;
  localparam logic [5:0] LEN_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID_REQ,
    ST_ID_WAIT,
    ST_FMT_REQ,
    ST_SEND,
    ST_DONE
  } state_e;

  // Codes above 3 saturate at the largest packet.
  function automatic logic [5:0] decode_len(input logic [2:0] code);
    case (code)
      3'd0:    decode_len = LEN_4;
      3'd1:    decode_len = LEN_8;
      3'd2:    decode_len = LEN_16;
      default: decode_len = LEN_32;
    endcase
  endfunction

endpackage

// File: rtl/mcdf_formatter.sv
// mcdf_formatter: packet formatter stage downstream of the channel arbiter.
// Asks the arbiter for a channel, latches its ID and length, requests
// downstream ownership, then streams one fixed-length packet with
// start/end framing. Flags disagreement between the slave end marker
// and the decoded length on the sticky err_o.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   f2a_id_req_o                  one-cycle channel decision request
//   a2f_id_i, a2f_pkglen_sel_i    granted channel ID / length code
//   a2f_val_i/_data_i/_end_i      selected slave word stream
//   f2a_ack_o                     word accepted this cycle
//   fmt_req_o, fmt_grant_i        downstream ownership handshake
//   fmt_chid_o, fmt_length_o      current packet channel / length
//   fmt_valid_o/_data_o/_start_o/_end_o  registered packet stream
//   err_o, err_clr_i              sticky framing error and its clear
module mcdf_formatter
  import mcdf_defs::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          f2a_id_req_o,
  input  logic [1:0]    a2f_id_i,
  input  logic [2:0]    a2f_pkglen_sel_i,
  input  logic          a2f_val_i,
  input  logic [DW-1:0] a2f_data_i,
  input  logic          a2f_end_i,
  output logic          f2a_ack_o,
  output logic          fmt_req_o,
  input  logic          fmt_grant_i,
  output logic [1:0]    fmt_chid_o,
  output logic [5:0]    fmt_length_o,
  output logic          fmt_valid_o,
  output logic [DW-1:0] fmt_data_o,
  output logic          fmt_start_o,
  output logic          fmt_end_o,
  output logic          err_o,
  input  logic          err_clr_i
);

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [1:0]    chid_q;
  logic [5:0]    len_q;
  logic          valid_q, start_q, end_q, err_q, err_d;
  logic [DW-1:0] data_q;

  logic accept, last, frame_bad;

  assign accept = (state_q == ST_SEND) && a2f_val_i;
  assign last   = (cnt_q == len_q - 6'd1);
  // Early end marker, or missing marker on the final word.
  assign frame_bad = accept && (a2f_end_i != last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:    state_d = ST_ID_REQ;
      ST_ID_REQ:  state_d = ST_ID_WAIT;
      ST_ID_WAIT: state_d = (a2f_id_i == ID_NONE) ? ST_IDLE : ST_FMT_REQ;
      ST_FMT_REQ: if (fmt_grant_i) state_d = ST_SEND;
      ST_SEND: begin
        if (accept) begin
          if (last) begin
            cnt_d   = 6'd0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A new error in the same cycle as a clear must survive.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (frame_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      chid_q  <= 2'b00;
      len_q   <= 6'd0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == ST_ID_WAIT && a2f_id_i != ID_NONE) begin
        chid_q <= a2f_id_i;
        len_q  <= decode_len(a2f_pkglen_sel_i);
      end
      valid_q <= accept;
      start_q <= accept && (cnt_q == 6'd0);
      end_q   <= accept && last;
      if (accept) data_q <= a2f_data_i;
    end
  end

  assign f2a_id_req_o = (state_q == ST_ID_REQ);
  assign fmt_req_o    = (state_q == ST_FMT_REQ);
  assign f2a_ack_o    = accept;
  assign fmt_chid_o   = chid_q;
  assign fmt_length_o = len_q;
  assign fmt_valid_o  = valid_q;
  assign fmt_data_o   = data_q;
  assign fmt_start_o  = start_q;
  assign fmt_end_o    = end_q;
  assign err_o        = err_q;

endmodule
